// File: rtl/ma_unit.sv
// ma_unit: multi-cycle memory-access stage with request/ready handshake,
// timeout abort and misaligned/illegal access detection.
module ma_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        isLd,
  input  logic        isSt,
  input  logic [31:0] aluResult,
  input  logic [31:0] op2,
  output logic        stall,
  output logic [31:0] ldResult,
  output logic        done,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;
  state_t state;
  logic [7:0] cnt;
  logic go;
  assign go = in_valid & (isLd | isSt);
  assign stall = ((state == IDLE) & go) | (state == REQ);
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ldResult  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: if (go) begin
          if ((isLd & isSt) | (|aluResult[1:0])) begin
            state <= ERR;
            err   <= 1'b1;
          end else begin
            state     <= REQ;
            mem_req   <= 1'b1;
            mem_we    <= isSt;
            mem_addr  <= aluResult;
            mem_wdata <= op2;
            cnt       <= '0;
          end
        end
        REQ: if (mem_ready) begin
          mem_req <= 1'b0;
          done    <= 1'b1;
          state   <= DONE;
          if (!mem_we) ldResult <= mem_rdata;
        end else if (cnt == 8'(TIMEOUT - 1)) begin
          // memory never answered: abandon the request
          mem_req <= 1'b0;
          err     <= 1'b1;
          state   <= ERR;
        end else begin
          cnt <= cnt + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ma_unit.sv
// tb_ma_unit: randomized scoreboard bench for ma_unit with a transaction-level
// reference model and a variable-latency memory responder.
module tb_ma_unit;
  localparam int TIMEOUT = 16;
  logic        clk = 0, reset = 0, in_valid = 0, isLd = 0, isSt = 0, mem_ready = 0;
  logic [31:0] aluResult = 0, op2 = 0, mem_rdata = 0;
  logic        stall, done, err, mem_req, mem_we;
  logic [31:0] ldResult, mem_addr, mem_wdata;
  int          checks = 0, errors = 0, cyc = 0;
  logic [31:0] ld_model = 0;
  typedef struct {logic e; logic [31:0] ld; int cyc;} exp_t;
  exp_t exp_q[$];

  ma_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .isLd(isLd), .isSt(isSt),
    .aluResult(aluResult), .op2(op2), .stall(stall), .ldResult(ldResult),
    .done(done), .err(err), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done/err pulse retires the oldest expected outcome.
  always @(negedge clk) begin
    if (reset && (done || err)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got done=%b err=%b expected none", done, err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("err_pulse", err, e.e);
        chk("done_pulse", done, !e.e);
        chk("ldResult", ldResult, e.ld);
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic run(input logic ld, input logic st, input logic [31:0] a,
                     input logic [31:0] d, input int waits, input logic [31:0] rd);
    int k, req_exp;
    exp_t e;
    @(negedge clk);
    in_valid = 1; isLd = ld; isSt = st; aluResult = a; op2 = d;
    mem_ready = 1'($urandom); mem_rdata = $urandom;
    if ((ld && st) || a[1:0] != 2'b00) begin
      e = '{1'b1, ld_model, cyc + 1}; req_exp = 0;
    end else if (waits >= TIMEOUT) begin
      e = '{1'b1, ld_model, cyc + 1 + TIMEOUT}; req_exp = TIMEOUT;
    end else begin
      if (ld) ld_model = rd;
      e = '{1'b0, ld_model, cyc + 2 + waits}; req_exp = waits + 1;
    end
    exp_q.push_back(e);
    #1 chk("issue_stall", stall, 1);
    @(negedge clk);
    in_valid = 0; isLd = 1'($urandom); isSt = 1'($urandom); aluResult = $urandom; op2 = $urandom;
    k = 0;
    while (mem_req && k < TIMEOUT + 4) begin
      chk("req_we", mem_we, st);
      chk("req_addr", mem_addr, a);
      chk("req_wdata", mem_wdata, d);
      chk("req_stall", stall, 1);
      mem_ready = (k == waits);
      mem_rdata = (k == waits) ? rd : $urandom;
      k++;
      @(negedge clk);
    end
    chk("req_cycles", k, req_exp);
    mem_ready = 1'($urandom);
    in_valid = 1; isLd = 1; isSt = 0; aluResult = 32'h40;
    #1 chk("retire_stall", stall, 0);
    @(negedge clk);
    chk("go_ignored", mem_req, 0);
    chk("pending", exp_q.size(), 0);
    in_valid = 0; isLd = 0; mem_ready = 0;
  endtask

  task automatic nop();
    @(negedge clk);
    in_valid = 1'($urandom); isLd = !in_valid && 1'($urandom); isSt = 0;
    aluResult = $urandom; mem_ready = 1'($urandom);
    #1 chk("nop_stall", stall, 0);
    @(negedge clk);
    chk("nop_req", mem_req, 0);
    in_valid = 0; isLd = 0; mem_ready = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req", mem_req, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ld", ldResult, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_stall", stall, 0);
    reset = 1;
    run(1, 0, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    run(0, 1, 32'h204, 32'h12345678, 3, 32'h0);
    run(1, 0, 32'h102, 32'h0, 0, 32'h55);
    run(1, 1, 32'h100, 32'h0, 0, 32'h66);
    run(1, 0, 32'h180, 32'h0, TIMEOUT + 5, 32'h77);
    run(1, 0, 32'h184, 32'h0, 1, 32'hCAFEF00D);
    run(1, 0, 32'h188, 32'h0, TIMEOUT - 1, 32'hA5A5A5A5);
    nop();
    // reset during the second REQ cycle abandons the load
    @(negedge clk);
    in_valid = 1; isLd = 1; isSt = 0; aluResult = 32'h300; mem_ready = 0;
    @(negedge clk);
    in_valid = 0;
    chk("rst_mid_req1", mem_req, 1);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst_mid_req", mem_req, 0);
    chk("rst_mid_ld", ldResult, 0);
    chk("rst_mid_stall", stall, 0);
    reset = 1; mem_ready = 1; mem_rdata = $urandom; ld_model = 0;
    repeat (3) begin
      @(negedge clk);
      chk("late_ready_req", mem_req, 0);
      chk("late_ready_done", done, 0);
    end
    mem_ready = 0;
    for (int i = 0; i < 150; i++) begin
      int ls, w;
      logic [31:0] a;
      ls = $urandom % 8;
      a = $urandom;
      if ($urandom % 6 != 0) a[1:0] = 2'b00;
      w = ($urandom % 8 == 0) ? TIMEOUT + int'($urandom % 3) : int'($urandom % 6);
      if ($urandom % 4 == 0) nop();
      run(ls <= 4, ls == 0 || ls >= 5, a, $urandom, w, $urandom);
    end
    chk("final_queue", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
